// File: rtl/block_checker_ext.sv
// Streaming begin/end keyword-nesting checker with a bounded nesting stack.
// Define BLOCK_CHECKER_CASE_EN to also track case/endcase with per-entry type bits.
module block_checker_ext #(
  parameter int MAX_DEPTH = 16,
  parameter int DEPTH_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               err
);

  // Keywords are left-aligned so that byte position p is bits [55-8p -: 8].
  localparam logic [55:0] KW_BEGIN = {"begin", 16'h0};
  localparam logic [55:0] KW_END   = {"end", 32'h0};
`ifdef BLOCK_CHECKER_CASE_EN
  localparam logic [55:0] KW_CASE    = {"case", 24'h0};
  localparam logic [55:0] KW_ENDCASE = "endcase";
`endif

  function automatic logic kw_hit(input logic [55:0] kw, input logic [2:0] len,
                                  input logic [2:0] p, input logic [7:0] c);
    logic [55:0] sh;
    sh = kw << (8 * p);
    return (p < len) && (sh[55:48] == c);
  endfunction

  logic [2:0] pos;
  logic       f_begin;
  logic       f_end;
`ifdef BLOCK_CHECKER_CASE_EN
  logic                 f_case;
  logic                 f_endcase;
  logic [MAX_DEPTH-1:0] typ;
  logic [MAX_DEPTH-1:0] typ_n;
  logic [MAX_DEPTH-1:0] typ_sh;
  logic                 fc_n;
  logic                 fec_n;
`endif

  logic               is_delim;
  logic               is_alpha;
  logic [7:0]         lc;
  logic [2:0]         pos_n;
  logic               fb_n;
  logic               fe_n;
  logic               w_begin, w_end, w_case, w_endcase;
  logic               t_begin, t_end, t_case, t_endcase;
  logic               push, pop, push_c, pop_c;
  logic               top_c;
  logic               bottom_c;
  logic [DEPTH_W-1:0] depth_n;
  logic               err_n;
  logic               result_n;

  always_comb begin
    is_delim = (in == 8'h20);
    is_alpha = ((in >= 8'h41) && (in <= 8'h5a)) || ((in >= 8'h61) && (in <= 8'h7a));
    lc       = in | 8'h20;
    pos_n    = (pos == 3'd7) ? pos : pos + 3'd1;

    fb_n    = f_begin & is_alpha & kw_hit(KW_BEGIN, 3'd5, pos, lc);
    fe_n    = f_end   & is_alpha & kw_hit(KW_END,   3'd3, pos, lc);
    // w_* describe the word being closed by a delimiter, t_* the word including this byte
    w_begin = f_begin && (pos == 3'd5);
    w_end   = f_end   && (pos == 3'd3);
    t_begin = fb_n && (pos_n == 3'd5);
    t_end   = fe_n && (pos_n == 3'd3);

`ifdef BLOCK_CHECKER_CASE_EN
    fc_n      = f_case    & is_alpha & kw_hit(KW_CASE,    3'd4, pos, lc);
    fec_n     = f_endcase & is_alpha & kw_hit(KW_ENDCASE, 3'd7, pos, lc);
    w_case    = f_case    && (pos == 3'd4);
    w_endcase = f_endcase && (pos == 3'd7);
    t_case    = fc_n  && (pos_n == 3'd4);
    t_endcase = fec_n && (pos_n == 3'd7);
    typ_sh    = typ >> (depth - DEPTH_W'(1));
    top_c     = typ_sh[0];
    typ_n     = typ;
`else
    w_case    = 1'b0;
    w_endcase = 1'b0;
    t_case    = 1'b0;
    t_endcase = 1'b0;
    top_c     = 1'b0;
`endif

    push    = w_begin | w_case;
    pop     = w_end | w_endcase;
    push_c  = w_case;
    pop_c   = w_endcase;
    depth_n = depth;
    err_n   = err;

    if (is_delim && !err) begin
      if (push) begin
        if (depth == DEPTH_W'(MAX_DEPTH)) begin
          err_n = 1'b1;
        end else begin
          depth_n = depth + DEPTH_W'(1);
`ifdef BLOCK_CHECKER_CASE_EN
          if (push_c) typ_n = typ | (MAX_DEPTH'(1) << depth);
          else        typ_n = typ & ~(MAX_DEPTH'(1) << depth);
`endif
        end
      end else if (pop) begin
        if (depth == '0)          err_n = 1'b1;
        else if (top_c != pop_c)  err_n = 1'b1;
        else                      depth_n = depth - DEPTH_W'(1);
      end
    end

`ifdef BLOCK_CHECKER_CASE_EN
    bottom_c = typ_n[0];
`else
    bottom_c = 1'b0;
`endif

    // Tentative end-of-stream view; a partial closing keyword can only balance depth 1
    if (err_n)                  result_n = 1'b0;
    else if (is_delim)          result_n = (depth_n == '0);
    else if (t_begin || t_case) result_n = 1'b0;
    else if (t_end)             result_n = (depth_n == DEPTH_W'(1)) && !bottom_c;
    else if (t_endcase)         result_n = (depth_n == DEPTH_W'(1)) && bottom_c;
    else                        result_n = (depth_n == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos       <= 3'd0;
      f_begin   <= 1'b1;
      f_end     <= 1'b1;
`ifdef BLOCK_CHECKER_CASE_EN
      f_case    <= 1'b1;
      f_endcase <= 1'b1;
      typ       <= '0;
`endif
      depth     <= '0;
      err       <= 1'b0;
      result    <= 1'b1;
    end else if (in_valid) begin
      pos       <= is_delim ? 3'd0 : pos_n;
      f_begin   <= is_delim | fb_n;
      f_end     <= is_delim | fe_n;
`ifdef BLOCK_CHECKER_CASE_EN
      f_case    <= is_delim | fc_n;
      f_endcase <= is_delim | fec_n;
      typ       <= typ_n;
`endif
      depth     <= depth_n;
      err       <= err_n;
      result    <= result_n;
    end
  end

endmodule

// File: tb/tb_block_checker_ext.sv
// Self-checking bench for block_checker_ext: directed scenarios plus random token streams
// compared byte-by-byte against a word/queue reference model.
module tb_block_checker_ext;
  localparam int MAXD = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in = 8'h0;
  logic       in_valid = 1'b0;
  logic       result;
  logic [1:0] depth;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  block_checker_ext #(.MAX_DEPTH(MAXD), .DEPTH_W(2)) dut (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .result(result), .depth(depth), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: current word as a byte queue, open blocks as a type queue (1 = case)
  logic [7:0] mw[$];
  bit         mq[$];
  bit         merr;

  function automatic bit is_letter(input logic [7:0] b);
    return ((b >= 8'h41) && (b <= 8'h5a)) || ((b >= 8'h61) && (b <= 8'h7a));
  endfunction

  function automatic bit word_is(input string k);
    if (k.len() != mw.size()) return 0;
    for (int i = 0; i < k.len(); i++)
      if (!is_letter(mw[i]) || ((mw[i] | 8'h20) != k[i])) return 0;
    return 1;
  endfunction

  // 0 none, 1 begin, 2 end, 3 case, 4 endcase
  function automatic int kw_of();
    if (word_is("begin")) return 1;
    if (word_is("end")) return 2;
`ifdef BLOCK_CHECKER_CASE_EN
    if (word_is("case")) return 3;
    if (word_is("endcase")) return 4;
`endif
    return 0;
  endfunction

  function automatic bit model_result();
    int k;
    if (merr) return 0;
    k = kw_of();
    if (k == 1 || k == 3) return 0;
    if (k == 2) return (mq.size() == 1) && (mq[0] == 1'b0);
    if (k == 4) return (mq.size() == 1) && (mq[0] == 1'b1);
    return mq.size() == 0;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int k;
    if (b == 8'h20) begin
      k = kw_of();
      if (!merr) begin
        if (k == 1 || k == 3) begin
          if (mq.size() == MAXD) merr = 1;
          else mq.push_back(k == 3);
        end else if (k == 2 || k == 4) begin
          if (mq.size() == 0) merr = 1;
          else if (mq[mq.size()-1] != (k == 4)) merr = 1;
          else void'(mq.pop_back());
        end
      end
      mw.delete();
    end else begin
      mw.push_back(b);
    end
  endtask

  task automatic model_clear();
    mw.delete();
    mq.delete();
    merr = 0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in = b;
    in_valid = 1'b1;
    model_byte(b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in = $urandom_range(0, 255);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({result, depth, err} !== 4'b1_00_0) begin
      n_bad++;
      $display("FAIL reset_state: got r/d/e %b/%0d/%b want 1/0/0", result, depth, err);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic_pair();
    do_reset();
    send_str("BEgiN");
    n_cmp++;
    if (result !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_tentative_begin: got %b want 0", result);
    end
    send_str(" ");
    n_cmp++;
    if ({result, depth, err} !== 4'b0_01_0) begin
      n_bad++;
      $display("FAIL basic_push: got r/d/e %b/%0d/%b want 0/1/0", result, depth, err);
    end
    send_str("x End ");
    n_cmp++;
    if ({result, depth, err} !== 4'b1_00_0) begin
      n_bad++;
      $display("FAIL basic_pair: got r/d/e %b/%0d/%b want 1/0/0", result, depth, err);
    end
  endtask

  task automatic test_tentative();
    do_reset();
    send_str("begin end");
    n_cmp++;
    if ({result, depth} !== 3'b1_01) begin
      n_bad++;
      $display("FAIL tentative_end: got r/d %b/%0d want 1/1", result, depth);
    end
    send_str("c");
    n_cmp++;
    if ({result, depth, err} !== 4'b0_01_0) begin
      n_bad++;
      $display("FAIL tentative_revert: got r/d/e %b/%0d/%b want 0/1/0", result, depth, err);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    send_str("a End ");
    n_cmp++;
    if ({result, depth, err} !== 4'b0_00_1) begin
      n_bad++;
      $display("FAIL underflow_set: got r/d/e %b/%0d/%b want 0/0/1", result, depth, err);
    end
    send_str("BEgiN End ");
    n_cmp++;
    if ({result, depth, err} !== 4'b0_00_1) begin
      n_bad++;
      $display("FAIL underflow_sticky: got r/d/e %b/%0d/%b want 0/0/1", result, depth, err);
    end
  endtask

  task automatic test_mismatch();
    logic [3:0] want;
    do_reset();
    send_str("begin case end ");
`ifdef BLOCK_CHECKER_CASE_EN
    want = 4'b0_10_1;
`else
    want = 4'b1_00_0;
`endif
    n_cmp++;
    if ({result, depth, err} !== want) begin
      n_bad++;
      $display("FAIL mismatch: got r/d/e %b/%0d/%b want %b/%0d/%b",
               result, depth, err, want[3], want[2:1], want[0]);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send_str("begin begin begin ");
    n_cmp++;
    if ({result, depth, err} !== 4'b0_11_0) begin
      n_bad++;
      $display("FAIL overflow_full: got r/d/e %b/%0d/%b want 0/3/0", result, depth, err);
    end
    send_str("begin");
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL overflow_early: got err %b want 0", err);
    end
    send_str(" ");
    n_cmp++;
    if ({result, depth, err} !== 4'b0_11_1) begin
      n_bad++;
      $display("FAIL overflow_set: got r/d/e %b/%0d/%b want 0/3/1", result, depth, err);
    end
  endtask

  task automatic test_valid_gaps_async_reset();
    do_reset();
    send_str("be");
    repeat (3) @(posedge clk);
    #1;
    send_str("gin ");
    n_cmp++;
    if ({result, depth, err} !== 4'b0_01_0) begin
      n_bad++;
      $display("FAIL gap_word: got r/d/e %b/%0d/%b want 0/1/0", result, depth, err);
    end
    send_str("beg");
    @(posedge clk);
    #3;
    reset = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if ({result, depth, err} !== 4'b1_00_0) begin
      n_bad++;
      $display("FAIL async_reset: got r/d/e %b/%0d/%b want 1/0/0", result, depth, err);
    end
    @(negedge clk);
    reset = 1'b1;
    send_str("in ");
    n_cmp++;
    if ({result, depth, err} !== 4'b1_00_0) begin
      n_bad++;
      $display("FAIL reset_discards_word: got r/d/e %b/%0d/%b want 1/0/0", result, depth, err);
    end
  endtask

  task automatic test_random();
    string pool[12];
    string tok;
    pool = '{"begin", "end", "case", "endcase", "BeGiN", "END", "x", "endc",
             "beginx", "b3gin", "EndCase", "endcasex"};
    for (int seq = 0; seq < 12; seq++) begin
      do_reset();
      for (int t = 0; t < 30; t++) begin
        tok = pool[$urandom_range(0, 11)];
        if ($urandom_range(0, 5) == 0) tok = {tok, " "};
        if ($urandom_range(0, 6) != 0) tok = {tok, " "};
        for (int i = 0; i < tok.len(); i++) begin
          if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
          send(tok[i]);
          n_cmp++;
          if ({result, depth, err} !== {model_result(), 2'(mq.size()), merr}) begin
            n_bad++;
            $display("FAIL random_seq%0d: got r/d/e %b/%0d/%b want %b/%0d/%b",
                     seq, result, depth, err, model_result(), mq.size(), merr);
          end
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic_pair();
    test_tentative();
    test_underflow();
    test_mismatch();
    test_overflow();
    test_valid_gaps_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/block_checker_ext.md
# block_checker_ext

Streaming keyword-nesting checker with a parametrised nesting stack. It consumes one ASCII byte per accepted cycle and tracks `begin`/`end` nesting, and optionally `case`/`endcase` nesting. It reports whether the stream so far is balanced, the current depth, and a sticky error. It sits in the P1 text-processing group as the generalised successor of the single-pair block checker, and adds a valid qualifier, depth bound, type matching and error reporting.

## Interface
- `MAX_DEPTH`, default 16: maximum open blocks held on the stack; range 1..255.
- `DEPTH_W`, default 5: width of `depth`. It must satisfy MAX_DEPTH < 2^DEPTH_W.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `in`, input, 8: ASCII byte.
- `in_valid`, input, 1: `in` is consumed at a rising edge only when this is 1. When it is 0, all state holds.
- `result`, output, 1: stream so far is balanced and error-free, evaluated as if the stream ended now.
- `depth`, output, DEPTH_W: number of committed open blocks, excluding the word in progress.
- `err`, output, 1: sticky structural error.

## Operation
- **Word rules**
  - Delimiter is byte 32 (space) only. Consecutive spaces form empty words with no effect.
  - Letters A–Z and a–z match keywords case-insensitively.
  - Any other byte inside a word makes that word a non-keyword.
  - A word longer than 7 bytes is a non-keyword.
- **Matcher**
  - Holds a position counter (0..7) and one candidate flag per keyword.
  - Flags are cleared on mismatch and reset at each delimiter.
- **Commit at delimiter**
  - `begin`: push type B.
  - `case`: push type C.
  - `end`: pop; the top must be B.
  - `endcase`: pop; the top must be C.
- **Error conditions**, each setting `err`:
  - Pop with an empty stack (underflow).
  - Pop with the wrong top type (mismatch).
  - Push while `depth`==MAX_DEPTH (overflow).
- **After `err`**
  - The stack freezes.
  - `err` and `result`=0 hold until reset.
- **Tentative evaluation**, recomputed after every accepted byte, where W is the current partial word:
  - If W exactly equals `begin` or `case`: `result`=0.
  - If W exactly equals `end` or `endcase`: `result` = (`depth`==1 and top type matches).
  - Otherwise: `result` = (`depth`==0).
  - `result` is always forced 0 when `err`=1.
  - Example: a stream ending in "end" that then continues "c" reverts to the committed evaluation. It ends as "endcase" only if the full word arrives.
- **Stack**
  - MAX_DEPTH×1-bit type array plus a pointer.
  - Type bits are only stored when the case feature is compiled in.

## Timing
- **Reset values**
  - `result`=1 (empty stream is balanced).
  - `depth`=0, `err`=0.
  - Matcher at position 0 with all flags set.
  - Stack pointer 0.
- **Latency**
  - All outputs are registered.
  - A byte accepted at edge k is fully reflected in `result`, `depth` and `err` after edge k (1-cycle latency).
  - No combinational path exists from `in` to the outputs.
- **Handshake**
  - There is no backpressure: every cycle with `in_valid`=1 consumes a byte.
  - Gaps in `in_valid` do not split words.
- **Commit timing**
  - A delimiter commits push/pop on the same edge that consumes it.
  - The matcher clears on that same edge.
- **Boundaries**
  - Overflow at exactly MAX_DEPTH pushes sets `err` on the delimiter edge; `depth` stays MAX_DEPTH.
  - Underflow leaves `depth` at 0.
  - Reset asserted mid-word discards the partial word immediately (asynchronous).
  - Reset deassertion takes effect from the next edge.

## Configuration
- **`BLOCK_CHECKER_CASE_EN` defined**
  - Recognises `case`/`endcase` in addition to `begin`/`end`.
  - Stores a type bit per stack entry.
  - Mismatch detection is active.
- **`BLOCK_CHECKER_CASE_EN` undefined**
  - `case` and `endcase` are ordinary words.
  - The stack reduces to a DEPTH_W counter and the type array is removed.
  - Mismatch can never occur; underflow and overflow remain.

## Test plan
- **Reset and basic pair.** Reset low, then stream "BEgiN x End " → after the final space: `result`=1, `depth`=0, `err`=0. After "BEgiN" (no space): `result`=0.
- **Tentative end and revert.** Stream "begin endc" → after 'd': `result`=1; after 'c': `result`=0, `depth`=1.
- **Sticky underflow.** Stream "a End BEgiN End " → `err`=1 after the first "End " space. Thereafter `result`=0 and `depth`=0, despite the later balanced pair.
- **Mismatch** (macro on). Stream "begin case end " → `err`=1 on the final space and `depth` freezes at 2. With the macro off, the same stream gives `depth`=0, `result`=1 and `err`=0 at the end.
- **Overflow** (MAX_DEPTH=2). Stream "begin begin begin " → `err`=1 after the third space, `depth`=2.
- **Valid gaps and async reset.** Stream "be", `in_valid`=0 for 3 cycles, then "gin " → `depth`=1. Pulse `reset` low between edges → outputs read 1/0/0 immediately, before the next edge.
